// File: rtl/mem_read_arbiter.sv
// Shares one memory read port between the fetch (IF) and load (LD) requesters, round-robin.
// Latency: accept at T, address valid from T+1, response one cycle after data (or after timeout).
// Backpressure: one transaction in flight; req_ready is only raised while idle, so requesters stall.
module mem_read_arbiter #(
  parameter int                     ADDR_WIDTH     = 64,
  parameter int                     DATA_WIDTH     = 32,
  parameter int                     TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0]  BUBBLE_WORD    = 90
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic                  if_flush,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  output logic                  if_rsp_valid,

  input  logic [ADDR_WIDTH-1:0] ld_req_addr,
  input  logic                  ld_req_valid,
  output logic                  ld_req_ready,
  output logic [DATA_WIDTH-1:0] ld_rsp_data,
  output logic                  ld_rsp_valid,

  output logic [ADDR_WIDTH-1:0] S_R_ADDR,
  output logic                  S_R_ADDR_VALID,
  input  logic [DATA_WIDTH-1:0] S_R_DATA,
  input  logic                  S_R_DATA_VALID,

  output logic                  busy,
  output logic                  timeout_err
);

  // Timer counts WAIT cycles 0..TIMEOUT_CYCLES-1 and never wraps.
  localparam int                  TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LD = 1'b1
  } requester_t;

  state_t                state_q,       state_d;
  requester_t            owner_q,       owner_d;
  requester_t            last_grant_q,  last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q,        addr_d;
  logic [DATA_WIDTH-1:0] data_q,        data_d;
  logic [TIMER_W-1:0]    timer_q,       timer_d;
  logic                  drop_q,        drop_d;
  logic                  timeout_err_q, timeout_err_d;
  // Last delivered word per requester, so each rsp_data holds between pulses.
  logic [DATA_WIDTH-1:0] if_hold_q,     if_hold_d;
  logic [DATA_WIDTH-1:0] ld_hold_q,     ld_hold_d;

  logic grant_if;
  logic grant_ld;
  logic deliver;

  // Round-robin grant while idle; both readies are forced low while reset is asserted.
  always_comb begin
    grant_if = 1'b0;
    grant_ld = 1'b0;
    if (state_q == ST_IDLE && reset) begin
      if (if_req_valid && ld_req_valid) begin
        if (last_grant_q == REQ_LD) begin
          grant_if = 1'b1;
        end else begin
          grant_ld = 1'b1;
        end
      end else begin
        grant_if = if_req_valid;
        grant_ld = ld_req_valid;
      end
    end
  end

  // Response goes out unless dropped earlier or killed by a flush during the RESP cycle itself.
  always_comb begin
    deliver = 1'b0;
    if (state_q == ST_RESP) begin
      deliver = !drop_q && !(owner_q == REQ_IF && if_flush);
    end
  end

  // Next-state and datapath updates for the IDLE/WAIT/RESP transaction sequence.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    addr_d        = addr_q;
    data_d        = data_q;
    timer_d       = timer_q;
    drop_d        = drop_q;
    timeout_err_d = timeout_err_q;
    if_hold_d     = if_hold_q;
    ld_hold_d     = ld_hold_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_if || grant_ld) begin
          owner_d      = grant_ld ? REQ_LD : REQ_IF;
          last_grant_d = grant_ld ? REQ_LD : REQ_IF;
          addr_d       = grant_ld ? ld_req_addr : if_req_addr;
          timer_d      = '0;
          drop_d       = 1'b0;
          state_d      = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // A fetch redirect kills the response but the memory access is allowed to finish.
        if (owner_q == REQ_IF && if_flush) begin
          drop_d = 1'b1;
        end
        // Real data wins over a timeout landing on the same cycle.
        if (S_R_DATA_VALID) begin
          data_d  = S_R_DATA;
          state_d = ST_RESP;
        end else if (timer_q == TIMER_LAST) begin
          data_d        = BUBBLE_WORD;
          timeout_err_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (deliver) begin
      if (owner_q == REQ_IF) begin
        if_hold_d = data_q;
      end else begin
        ld_hold_d = data_q;
      end
    end
  end

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= REQ_IF;
      last_grant_q  <= REQ_LD;
      addr_q        <= '0;
      data_q        <= '0;
      timer_q       <= '0;
      drop_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      if_hold_q     <= '0;
      ld_hold_q     <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      timer_q       <= timer_d;
      drop_q        <= drop_d;
      timeout_err_q <= timeout_err_d;
      if_hold_q     <= if_hold_d;
      ld_hold_q     <= ld_hold_d;
    end
  end

  // Output decode; address is only driven while the memory access is outstanding.
  always_comb begin
    if_req_ready   = grant_if;
    ld_req_ready   = grant_ld;
    S_R_ADDR_VALID = (state_q == ST_WAIT);
    S_R_ADDR       = (state_q == ST_WAIT) ? addr_q : '0;
    if_rsp_valid   = deliver && (owner_q == REQ_IF);
    ld_rsp_valid   = deliver && (owner_q == REQ_LD);
    if_rsp_data    = if_rsp_valid ? data_q : if_hold_q;
    ld_rsp_data    = ld_rsp_valid ? data_q : ld_hold_q;
    busy           = (state_q != ST_IDLE);
    timeout_err    = timeout_err_q;
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: transaction-level model of grants, timeouts and flush drops.
// Driver issues one transaction per round and pushes the expected response into a queue.
// A negedge monitor pops and compares every response pulse the DUT produces.
module tb_mem_read_arbiter;

  localparam int          AW     = 64;
  localparam int          DW     = 32;
  localparam int          TO     = 6;
  localparam logic [31:0] BUBBLE = 32'd90;

  logic          clk;
  logic          reset;
  logic [AW-1:0] if_req_addr;
  logic          if_req_valid;
  logic          if_req_ready;
  logic          if_flush;
  logic [DW-1:0] if_rsp_data;
  logic          if_rsp_valid;
  logic [AW-1:0] ld_req_addr;
  logic          ld_req_valid;
  logic          ld_req_ready;
  logic [DW-1:0] ld_rsp_data;
  logic          ld_rsp_valid;
  logic [AW-1:0] S_R_ADDR;
  logic          S_R_ADDR_VALID;
  logic [DW-1:0] S_R_DATA;
  logic          S_R_DATA_VALID;
  logic          busy;
  logic          timeout_err;

  mem_read_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO),
    .BUBBLE_WORD    (BUBBLE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .if_req_addr    (if_req_addr),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_flush       (if_flush),
    .if_rsp_data    (if_rsp_data),
    .if_rsp_valid   (if_rsp_valid),
    .ld_req_addr    (ld_req_addr),
    .ld_req_valid   (ld_req_valid),
    .ld_req_ready   (ld_req_ready),
    .ld_rsp_data    (ld_rsp_data),
    .ld_rsp_valid   (ld_rsp_valid),
    .S_R_ADDR       (S_R_ADDR),
    .S_R_ADDR_VALID (S_R_ADDR_VALID),
    .S_R_DATA       (S_R_DATA),
    .S_R_DATA_VALID (S_R_DATA_VALID),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          owner;  // 0 = IF, 1 = LD
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            last_grant_m;   // 0 = IF, 1 = LD
  logic          exp_terr;
  logic [DW-1:0] hold_if;
  logic [DW-1:0] hold_ld;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_grant_m = 1;
    exp_terr     = 1'b0;
    hold_if      = '0;
    hold_ld      = '0;
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"},    64'({if_req_ready, ld_req_ready}), 64'(0));
    chk({tag, "_rspv"},     64'({if_rsp_valid, ld_rsp_valid}), 64'(0));
    chk({tag, "_addrv"},    64'(S_R_ADDR_VALID), 64'(0));
    chk({tag, "_addr"},     S_R_ADDR, 64'(0));
    chk({tag, "_busy"},     64'(busy), 64'(0));
    chk({tag, "_terr"},     64'(timeout_err), 64'(0));
    chk({tag, "_rspdata"},  {if_rsp_data, ld_rsp_data}, 64'(0));
  endtask

  // Enters at posedge+1; asserts reset with both requesters valid, releases two edges later.
  task automatic apply_reset();
    @(posedge clk); #1;
    reset          = 1'b0;
    if_req_valid   = 1'b1;
    ld_req_valid   = 1'b1;
    S_R_DATA_VALID = 1'b0;
    if_flush       = 1'b0;
    #2;
    check_all_zero("rst");
    model_reset();
    if_req_valid = 1'b0;
    ld_req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // One transaction; entered and left at posedge+1 with the DUT idle.
  // fmode: 0 none, 1 flush in accept cycle, 2 flush during WAIT, 3 flush in RESP cycle.
  task automatic do_round(input bit v_if, input bit v_ld,
                          input logic [AW-1:0] a_if, input logic [AW-1:0] a_ld,
                          input int k, input int fmode, input logic [DW-1:0] mdata,
                          input bit hold);
    int            win;
    int            got;
    int            wcyc;
    int            fj;
    bit            drop;
    logic [AW-1:0] exp_addr;
    exp_t          e;

    if (v_if && v_ld) win = (last_grant_m == 0) ? 1 : 0;
    else if (v_if)    win = 0;
    else              win = 1;
    last_grant_m = win;
    wcyc     = (k <= TO) ? k : TO;
    drop     = (win == 0) && (fmode == 2 || fmode == 3);
    fj       = (fmode == 2) ? $urandom_range(1, wcyc) : 0;
    exp_addr = win ? a_ld : a_if;

    if_req_valid   = v_if;
    ld_req_valid   = v_ld;
    if_req_addr    = a_if;
    ld_req_addr    = a_ld;
    if_flush       = (fmode == 1);
    S_R_DATA_VALID = 1'($urandom_range(0, 1));
    S_R_DATA       = $urandom;

    got = -1;
    for (int c = 0; c < 4 && got < 0; c++) begin
      @(negedge clk);
      if (if_req_ready && !ld_req_ready)      got = 0;
      else if (ld_req_ready && !if_req_ready) got = 1;
      else if (if_req_ready && ld_req_ready)  got = 2;
      if (got < 0) begin
        @(posedge clk); #1;
      end
    end
    chk("grant", 64'(got), 64'(win));
    if (got < 0) begin
      if_req_valid = 1'b0;
      ld_req_valid = 1'b0;
      return;
    end

    if (!drop) begin
      e.owner = win[0];
      e.data  = (k <= TO) ? mdata : BUBBLE;
      exp_q.push_back(e);
    end
    if (k > TO) exp_terr = 1'b1;

    for (int i = 1; i <= wcyc; i++) begin
      @(posedge clk); #1;
      if_req_valid   = hold ? v_if : 1'($urandom_range(0, 1));
      ld_req_valid   = hold ? v_ld : 1'($urandom_range(0, 1));
      if_req_addr    = {$urandom, $urandom};
      ld_req_addr    = {$urandom, $urandom};
      if_flush       = (i == fj);
      S_R_DATA_VALID = (i == k);
      S_R_DATA       = (i == k) ? mdata : $urandom;
      @(negedge clk);
      chk("wait_addr_valid", 64'(S_R_ADDR_VALID), 64'(1));
      chk("wait_addr", S_R_ADDR, exp_addr);
      chk("wait_busy", 64'(busy), 64'(1));
      chk("wait_ready", 64'({if_req_ready, ld_req_ready}), 64'(0));
    end

    // RESP cycle: late memory data after a timeout must be ignored.
    @(posedge clk); #1;
    if_req_valid   = 1'b0;
    ld_req_valid   = 1'b0;
    if_flush       = (fmode == 3);
    S_R_DATA_VALID = (k > TO);
    S_R_DATA       = $urandom;
    @(negedge clk);
    chk("resp_if_valid", 64'(if_rsp_valid), 64'(win == 0 && !drop));
    chk("resp_ld_valid", 64'(ld_rsp_valid), 64'(win == 1));
    chk("resp_addr_valid", 64'(S_R_ADDR_VALID), 64'(0));
    chk("resp_terr", 64'(timeout_err), 64'(exp_terr));

    @(posedge clk); #1;
    if_flush       = 1'b0;
    S_R_DATA_VALID = 1'b0;
    chk("idle_busy", 64'(busy), 64'(0));
  endtask

  // Response monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset) begin
      chk("rsp_onehot", 64'(if_rsp_valid & ld_rsp_valid), 64'(0));
      if (if_rsp_valid || ld_rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: actual if=%0b/%0h ld=%0b/%0h required none (t=%0t)",
                   if_rsp_valid, if_rsp_data, ld_rsp_valid, ld_rsp_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_owner", 64'(ld_rsp_valid), 64'(mon_e.owner));
          chk("rsp_data", 64'(ld_rsp_valid ? ld_rsp_data : if_rsp_data), 64'(mon_e.data));
          if (mon_e.owner) hold_ld = mon_e.data;
          else             hold_if = mon_e.data;
        end
      end else begin
        chk("rsp_hold", {if_rsp_data, ld_rsp_data}, {hold_if, hold_ld});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int r;
    int fm;
    reset          = 1'b0;
    if_req_addr    = '0;
    if_req_valid   = 1'b0;
    if_flush       = 1'b0;
    ld_req_addr    = '0;
    ld_req_valid   = 1'b0;
    S_R_DATA       = '0;
    S_R_DATA_VALID = 1'b0;
    model_reset();
    apply_reset();

    // Single fetch, memory answers one cycle after address valid.
    do_round(1, 0, 64'h1000, 64'h0, 1, 0, 32'h0000_0013, 0);

    // Both held valid continuously from reset: IF, LD, IF, LD.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_round(1, 1, 64'h2000 + 64'(i), 64'h8000 + 64'(i), 2, 0, 32'hA000_0000 + 32'(i), 1);
    end

    // Load with 5-cycle memory delay.
    do_round(0, 1, 64'h3000, 64'h4000, 5, 0, 32'h1234_5678, 0);
    // Data on the last timer cycle wins, no error.
    do_round(1, 0, 64'h5000, 64'h0, TO, 0, 32'h0BAD_F00D, 0);
    // No data: bubble word and sticky error; late data ignored.
    do_round(0, 1, 64'h0, 64'h6000, TO + 3, 0, 32'hFFFF_FFFF, 0);
    do_round(1, 0, 64'h7000, 64'h0, 2, 0, 32'h0000_0042, 0);

    // Flushed fetch with a pending load behind it.
    apply_reset();
    do_round(1, 1, 64'h9000, 64'hA000, 3, 2, 32'hDEAD_BEEF, 1);
    do_round(0, 1, 64'h0, 64'hA000, 2, 0, 32'h5555_AAAA, 0);
    // Flush in accept cycle is harmless; flush never touches LD.
    do_round(1, 0, 64'hB000, 64'h0, 2, 1, 32'h1111_2222, 0);
    do_round(0, 1, 64'h0, 64'hC000, 3, 2, 32'h3333_4444, 0);

    // Reset in the middle of WAIT.
    if_req_valid = 1'b1;
    if_req_addr  = 64'hABC0;
    @(negedge clk);
    chk("rstw_grant", 64'(if_req_ready), 64'(1));
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstw_in_wait", 64'(S_R_ADDR_VALID), 64'(1));
    reset        = 1'b0;
    if_req_valid = 1'b1;
    ld_req_valid = 1'b1;
    #2;
    check_all_zero("rstw");
    model_reset();
    if_req_valid = 1'b0;
    ld_req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    do_round(1, 1, 64'hD000, 64'hE000, 1, 0, 32'h7777_8888, 0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(1, 3);
      fm = $urandom_range(0, 5);
      if (fm > 3) fm = 0;
      do_round(r[0], r[1], {$urandom, $urandom}, {$urandom, $urandom},
               $urandom_range(1, TO + 2), fm, $urandom, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
